// File: rtl/adc_code_to_bcd.sv
// ADC code to millivolt + 4-digit BCD converter: one-cycle scale, 14-cycle double dabble, one-cycle result.
// Build option ADC2BCD_ROUND_EN selects round-half-up scaling instead of truncation.
module adc_code_to_bcd #(
    parameter int CODE_W  = 12,
    parameter int VREF_MV = 3300
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    output logic              busy,
    output logic              done,
    output logic [13:0]       mv,
    output logic [15:0]       bcd
);

    localparam int PROD_W = CODE_W + 15;
    localparam int BIN_W  = 14;
    localparam int SR_W   = 16 + BIN_W;
    localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

`ifdef ADC2BCD_ROUND_EN
    localparam logic [PROD_W-1:0] ROUND_ADD = PROD_W'(1) << (CODE_W - 1);
`else
    localparam logic [PROD_W-1:0] ROUND_ADD = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCALE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [BIN_W-1:0]  mv_int_q, mv_int_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BIN_W-1:0]  mv_q, mv_d;
    logic [15:0]       bcd_q, bcd_d;

    logic [PROD_W-1:0] prod_rnd;
    logic [BIN_W-1:0]  mv_scaled;
    logic [SR_W-1:0]   sr_adj;
    logic [SR_W-1:0]   sr_shift;

    // Product is one bit wider than needed so the rounding add can never wrap.
    assign prod_rnd  = PROD_W'(code_q) * PROD_W'(VREF_MV) + ROUND_ADD;
    assign mv_scaled = BIN_W'(prod_rnd >> CODE_W);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dabble
            localparam int LSB = BIN_W + 4 * gi;
            assign sr_adj[LSB +: 4] = (sr_q[LSB +: 4] >= 4'd5) ? sr_q[LSB +: 4] + 4'd3
                                                               : sr_q[LSB +: 4];
        end
    endgenerate

    assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
    assign sr_shift          = sr_adj << 1;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        mv_int_d = mv_int_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        mv_d     = mv_q;
        bcd_d    = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    code_d  = code;
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                mv_int_d = mv_scaled;
                sr_d     = {16'b0, mv_scaled};
                cnt_d    = 4'd0;
                state_d  = S_CONVERT;
            end
            S_CONVERT: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + 4'd1;
                // Outputs load on the edge entering DONE so they are valid while done is high.
                if (cnt_q == LAST_ITER) begin
                    mv_d    = mv_int_q;
                    bcd_d   = sr_shift[SR_W-1:BIN_W];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            code_q   <= '0;
            mv_int_q <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            mv_q     <= '0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            mv_int_q <= mv_int_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            mv_q     <= mv_d;
            bcd_q    <= bcd_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign mv   = mv_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_adc_code_to_bcd.sv
// Scoreboard bench for adc_code_to_bcd: a cycle-level protocol model queues expected results,
// a negedge monitor pops them when done is seen and checks busy/mv/bcd every cycle.
module tb_adc_code_to_bcd;

    localparam int CW   = 12;
    localparam int VREF = 3300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] code = '0;
    logic        busy;
    logic        done;
    logic [13:0] mv;
    logic [15:0] bcd;

    adc_code_to_bcd #(.CODE_W(CW), .VREF_MV(VREF)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .code  (code),
        .busy  (busy),
        .done  (done),
        .mv    (mv),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] mv;
        logic [15:0] bcd;
        int          cyc;
        int          code;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int free_at = 0;
    int last_acc = -1;
    int flush_gen = 0;
    bit chk_en = 1'b0;

    function automatic exp_t ref_conv(int c, int at);
        exp_t   e;
        longint p;
        int     m;
        p = longint'(c) * VREF;
`ifdef ADC2BCD_ROUND_EN
        p = p + (1 << (CW - 1));
`endif
        m = int'(p / (longint'(1) << CW));
        e.mv   = 14'(m);
        e.bcd  = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
        e.cyc  = at;
        e.code = c;
        return e;
    endfunction

    // Protocol model: a start is accepted when the converter is free; result due 16 cycles later.
    always @(posedge clk) begin
        if (rst) begin
            free_at   = cyc + 1;
            flush_gen = flush_gen + 1;
        end else if (start && cyc >= free_at) begin
            exp_q.push_back(ref_conv(int'(code), cyc + 16));
            last_acc = cyc;
            free_at  = cyc + 17;
        end
        cyc = cyc + 1;
    end

    // Monitor
    int          seen_flush = 0;
    logic [13:0] held_mv = '0;
    logic [15:0] held_bcd = '0;
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (seen_flush != flush_gen) begin
            seen_flush = flush_gen;
            exp_q.delete();
            held_mv  = '0;
            held_bcd = '0;
        end
        if (chk_en) begin
            if (done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d got done=1 required done=0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    held_mv  = e.mv;
                    held_bcd = e.bcd;
                    checks++;
                    if (e.cyc != cyc) begin
                        errors++;
                        $display("FAIL done_cycle code=%0d got cyc=%0d required cyc=%0d", e.code, cyc, e.cyc);
                    end
                    $display("conv code=%0d cyc=%0d mv=%0d bcd=%h (required mv=%0d bcd=%h)",
                             e.code, cyc, mv, bcd, e.mv, e.bcd);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_done code=%0d got done=0 at cyc=%0d required done=1", e.code, cyc);
            end
            exp_busy = (cyc > last_acc) && (cyc < free_at);
            checks += 3;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got %b required %b", cyc, busy, exp_busy);
            end
            if (mv !== held_mv) begin
                errors++;
                $display("FAIL mv cyc=%0d got %0d required %0d", cyc, mv, held_mv);
            end
            if (bcd !== held_bcd) begin
                errors++;
                $display("FAIL bcd cyc=%0d got %h required %h", cyc, bcd, held_bcd);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int c);
        start = 1'b1;
        code  = 12'(c);
        @(negedge clk);
        start = 1'b0;
        code  = 12'($urandom);
    endtask

    int dir_codes[6] = '{2048, 1241, 0, 4095, 1, 2047};

    initial begin
        idle(2);
        chk_en = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);

        foreach (dir_codes[i]) begin
            pulse(dir_codes[i]);
            idle(19);
        end

        // Second start while busy must be dropped.
        pulse(2048);
        idle(4);
        pulse(100);
        idle(20);

        // Reset mid-conversion discards the result.
        pulse(2048);
        idle(7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(25);

        // start and rst together: reset wins.
        rst = 1'b1;
        pulse(777);
        rst = 1'b0;
        idle(20);

        // Start held continuously.
        start = 1'b1;
        code  = 12'd4095;
        idle(52);
        start = 1'b0;
        idle(20);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       code = 12'd0;
                1:       code = 12'd4095;
                default: code = 12'($urandom_range(0, 4095));
            endcase
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;

        for (int w = 0; w < 40 && exp_q.size() != 0; w++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending results required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
